// File: rtl/hdmi_timing_ctrl_if.sv
// Video timing bundle between the timing controller and its consumers.
// The run request goes in. Registered raster position, sync and strobe outputs come out.
interface hdmi_timing_ctrl_if;
    logic        i_enable;
    logic        o_de;
    logic [1:0]  o_ctrl;
    logic [11:0] o_x;
    logic [11:0] o_y;
    logic        o_line_start;
    logic        o_frame_start;
    logic        o_busy;

    modport master (
        output i_enable,
        input  o_de, o_ctrl, o_x, o_y, o_line_start, o_frame_start, o_busy
    );

    modport slave (
        input  i_enable,
        output o_de, o_ctrl, o_x, o_y, o_line_start, o_frame_start, o_busy
    );
endinterface

// File: rtl/hdmi_timing_ctrl.sv
// HDMI/DVI raster timing generator. It emits only whole frames and registers every output.
// Every output is decoded from the same next-state position as o_x/o_y.
module hdmi_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic               i_pixclk,
    input  logic               i_reset_n,
    hdmi_timing_ctrl_if.slave  tim
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // The bounds are 13 bits wide so that a boundary of exactly 4096 still compares correctly.
    localparam logic [12:0] H_DE_END = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG   = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_DE_END = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEG   = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [11:0] h_q, h_d, v_q, v_d;
    logic [11:0] h_inc, v_inc;
    logic        h_end, frame_end;
    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic        ls_q, ls_d, fs_q, fs_d, busy_q, busy_d;
    logic        active;

    always_comb begin
        h_end     = (h_q == H_LAST);
        frame_end = h_end && (v_q == V_LAST);
        h_inc     = h_end ? 12'd0 : h_q + 12'd1;
        v_inc     = h_end ? ((v_q == V_LAST) ? 12'd0 : v_q + 12'd1) : v_q;

        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (tim.i_enable) begin
                    state_d = RUN;
                    h_d     = 12'd0;
                    v_d     = 12'd0;
                end
            end
            RUN, DRAIN: begin
                // Stop only on the last pixel of a frame. The count parks at (H_LAST, V_LAST).
                if (frame_end && !tim.i_enable) begin
                    state_d = IDLE;
                end else begin
                    h_d     = h_inc;
                    v_d     = v_inc;
                    state_d = tim.i_enable ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                h_d     = H_LAST;
                v_d     = V_LAST;
            end
        endcase
    end

    always_comb begin
        active = (state_d != IDLE);
        de_d   = active && ({1'b0, h_d} < H_DE_END) && ({1'b0, v_d} < V_DE_END);
        hs_d   = (active && ({1'b0, h_d} >= HS_BEG) && ({1'b0, h_d} < HS_END)) ? HS_POL : ~HS_POL;
        vs_d   = (active && ({1'b0, v_d} >= VS_BEG) && ({1'b0, v_d} < VS_END)) ? VS_POL : ~VS_POL;
        ls_d   = active && (h_d == 12'd0);
        fs_d   = ls_d && (v_d == 12'd0);
        busy_d = active;
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    assign tim.o_de          = de_q;
    assign tim.o_ctrl        = {vs_q, hs_q};
    assign tim.o_x           = h_q;
    assign tim.o_y           = v_q;
    assign tim.o_line_start  = ls_q;
    assign tim.o_frame_start = fs_q;
    assign tim.o_busy        = busy_q;
endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Directed scoreboard bench for hdmi_timing_ctrl on a 15x8 raster (H 8/2/3/2, V 4/1/2/1).
// The model tracks a linear frame position. It does not track separate h/v counters.
module tb_hdmi_timing_ctrl;
    localparam int HT = 15;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic        de;
        logic [1:0]  ctrl;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic        busy;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    hdmi_timing_ctrl_if tif ();

    hdmi_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .i_pixclk (clk),
        .i_reset_n(rst_n),
        .tim      (tif)
    );

    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   mst      = 0;          // 0 idle, 1 run, 2 drain
    int   mp       = FT - 1;     // linear position y*HT + x
    int   cyc      = 0;
    int   last_fs  = -1;
    bit   per_on   = 1'b0;
    exp_t sb[$];

    function automatic exp_t model_out();
        exp_t e;
        int   x, y;
        bit   act;
        x      = mp % HT;
        y      = mp / HT;
        act    = (mst != 0);
        e.x    = 12'(x);
        e.y    = 12'(y);
        e.de   = act && x < 8 && y < 4;
        e.ctrl = {~(act && y >= 5 && y <= 6), ~(act && x >= 10 && x <= 12)};
        e.ls   = act && x == 0;
        e.fs   = act && mp == 0;
        e.busy = act;
        return e;
    endfunction

    task automatic model_edge(input bit en);
        if (mst == 0) begin
            if (en) begin mst = 1; mp = 0; end
        end else if (mp == FT - 1 && !en) begin
            mst = 0;
        end else begin
            mp  = (mp + 1) % FT;
            mst = en ? 1 : 2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input string pfx, input exp_t e);
        chk({pfx, ".de"},   32'(tif.o_de),          32'(e.de));
        chk({pfx, ".ctrl"}, 32'(tif.o_ctrl),        32'(e.ctrl));
        chk({pfx, ".x"},    32'(tif.o_x),           32'(e.x));
        chk({pfx, ".y"},    32'(tif.o_y),           32'(e.y));
        chk({pfx, ".ls"},   32'(tif.o_line_start),  32'(e.ls));
        chk({pfx, ".fs"},   32'(tif.o_frame_start), 32'(e.fs));
        chk({pfx, ".busy"}, 32'(tif.o_busy),        32'(e.busy));
    endtask

    task automatic step(input bit en);
        exp_t e;
        tif.i_enable = en;
        model_edge(en);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check_all("step", e);
        if (tif.o_frame_start === 1'b1) begin
            if (per_on && last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(FT));
            last_fs = cyc;
        end
    endtask

    task automatic reset_check();
        mst = 0;
        mp  = FT - 1;
        sb.delete();
        check_all("reset", model_out());
    endtask

    initial begin
        int  n;
        bit  found;

        tif.i_enable = 1'b1;
        #1 rst_n = 1'b0;
        #2 reset_check();
        @(negedge clk) rst_n = 1'b1;

        // The first edge after release starts the frame, and the raster then runs freely.
        per_on  = 1'b1;
        last_fs = -1;
        step(1'b1);
        chk("first_fs", 32'(tif.o_frame_start), 32'd1);
        repeat (250) step(1'b1);

        // Enable drops at (3,1). The frame drains to (14,7) and then parks in IDLE.
        per_on = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            if (tif.o_x === 12'd3 && tif.o_y === 12'd1) begin found = 1'b1; break; end
            step(1'b1);
        end
        chk("seek_3_1", 32'(found), 32'd1);
        n     = 0;
        found = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            step(1'b0);
            n++;
            if (tif.o_busy === 1'b0) begin found = 1'b1; break; end
        end
        chk("drain_done", 32'(found), 32'd1);
        chk("drain_len", 32'(n), 32'd102);
        chk("idle_x", 32'(tif.o_x), 32'd14);
        chk("idle_y", 32'(tif.o_y), 32'd7);
        repeat (5) step(1'b0);

        // A 5-cycle enable glitch in mid-frame must not disturb the raster cadence.
        per_on  = 1'b1;
        last_fs = -1;
        repeat (40) step(1'b1);
        repeat (5) step(1'b0);
        repeat (200) step(1'b1);

        // Reset at (5,2) aborts the frame asynchronously, and the next frame starts at release.
        per_on = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 2 * FT; i++) begin
            if (tif.o_x === 12'd5 && tif.o_y === 12'd2) begin found = 1'b1; break; end
            step(1'b1);
        end
        chk("seek_5_2", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1 reset_check();
        @(negedge clk) rst_n = 1'b1;
        step(1'b1);
        chk("post_rst_fs", 32'(tif.o_frame_start), 32'd1);
        repeat (20) step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hdmi_timing_ctrl.md
HDMI_TIMING_CTRL -- requirements
Module: hdmi_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter HS_POL, default 0; sync asserted level for hsync (0 = active-low).
REQ-010 SHALL have parameter VS_POL, default 0; sync asserted level for vsync.
REQ-011 i_pixclk  input  1  pixel clock; the only clock; all flops on its rising edge.
REQ-012 i_reset_n  input  1  asynchronous, active-low reset.
REQ-013 i_enable  input  1  run request; level-sensitive.
REQ-014 o_de  output  1  data enable to all three TMDS encoder lanes.
REQ-015 o_ctrl  output  2  {vsync, hsync} at line level; drives the blue-lane encoder control input.
REQ-016 o_x  output  12  horizontal position counter h.
REQ-017 o_y  output  12  vertical position counter v.
REQ-018 o_line_start  output  1  one-cycle pulse when h = 0.
REQ-019 o_frame_start  output  1  one-cycle pulse when h = 0 and v = 0.
REQ-020 o_busy  output  1  high in RUN or DRAIN.

Function
REQ-021 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; each SHALL be at most 4096.
REQ-022 Horizontal order within a line SHALL be active (h 0..H_ACTIVE-1), then front porch, sync, back porch, ending at h = H_TOTAL-1.
REQ-023 Vertical order SHALL be the same in lines; v SHALL increment only on the edge where h wraps from H_TOTAL-1 to 0.
REQ-024 v SHALL wrap from V_TOTAL-1 to 0 on the same edge that h wraps.
REQ-025 All outputs SHALL be driven directly from flops updated on the same edge as h and v; output decode SHALL have zero added latency relative to o_x/o_y.
REQ-026 o_de SHALL be 1 iff h < H_ACTIVE and v < V_ACTIVE and state = RUN or DRAIN.
REQ-027 hsync SHALL be asserted (HS_POL) iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise ~HS_POL.
REQ-028 vsync SHALL be asserted (VS_POL) for all h of lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; otherwise ~VS_POL.
REQ-029 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-030 IDLE: h = H_TOTAL-1, v = V_TOTAL-1, o_de = 0, syncs inactive, pulses 0; on an edge with i_enable = 1, go to RUN with h = 0, v = 0.
REQ-031 RUN: counters advance every cycle; if i_enable = 0 at an edge, go to DRAIN and keep advancing.
REQ-032 DRAIN: counters advance; if i_enable returns to 1, go back to RUN with no disturbance of the count.
REQ-033 DRAIN: at the edge where h = H_TOTAL-1 and v = V_TOTAL-1 with i_enable = 0, go to IDLE; with i_enable = 1, go to RUN and wrap to (0,0).
REQ-034 The frame SHALL never be truncated by i_enable; only whole frames are emitted.
REQ-035 o_line_start and o_frame_start SHALL never assert in IDLE.

Reset
REQ-036 On i_reset_n = 0, the block SHALL immediately (asynchronously) enter IDLE with h = H_TOTAL-1 and v = V_TOTAL-1.
REQ-037 Reset outputs: o_de 0, o_ctrl {~VS_POL, ~HS_POL}, o_x H_TOTAL-1, o_y V_TOTAL-1, o_line_start 0, o_frame_start 0, o_busy 0.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no drain; after release, the block SHALL wait for i_enable.

Verification
(The bench configuration is H 8/2/3/2 (H_TOTAL 15) and V 4/1/2/1 (V_TOTAL 8), with HS_POL = VS_POL = 0.)
REQ-039 Reset released with i_enable = 1 -> on the first edge, o_frame_start = 1, o_x = 0, o_y = 0, o_de = 1; o_de stays high for 8 cycles, then drops at o_x = 8.
REQ-040 Steady run -> o_ctrl[0] = 0 exactly at o_x 10..12 on every line; o_ctrl[1] = 0 for all of lines 5..6; o_frame_start period is 120 cycles.
REQ-041 i_enable dropped at (x 3, y 1) -> counting continues to (14,7); the next edge gives IDLE with o_busy = 0, o_de = 0, and o_x/o_y held at 14/7.
REQ-042 i_enable pulsed low for 5 cycles mid-frame -> no break in o_x/o_y sequence and the next o_frame_start arrives exactly 120 cycles after the previous one.
REQ-043 i_reset_n asserted at (x 5, y 2) -> outputs take reset values before the next edge, and the next o_frame_start occurs on the first edge after release with i_enable = 1.
